// File: rtl/fir_stream_pkg.sv
// Shared types and constants for the FIR result serial streamer.
// Optional parity frame bit is enabled by defining FIR_STREAM_PARITY_EN.
package fir_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_WAIT    = 3'd2,
        S_START_B = 3'd3,
        S_DATA_B  = 3'd4,
        S_PAR_B   = 3'd5,
        S_STOP_B  = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Serial bits per frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned n, input bit parity);
        return n + 32'd2 + (parity ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/fir_bit_timer.sv
// Bit-period down-counter: tick marks the last clock of each serial bit.
// Auto-reloads on tick; load realigns the period to the next cycle.
module fir_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    output logic tick_c_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || (cnt_q == '0)) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c_o = (cnt_q == '0);

endmodule

// File: rtl/fir_result_streamer.sv
// Reads a block of words from data memory and streams each as a framed serial word on out.
// Defining FIR_STREAM_PARITY_EN adds an even-parity bit before the stop bit.
module fir_result_streamer
    import fir_stream_pkg::*;
#(
    parameter int unsigned N            = 24,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     base_addr,
    input  logic [CNT_W-1:0] count,
    output logic [N-1:0]     mem_addr,
    output logic             mem_rd_en,
    input  logic [N-1:0]     mem_rdata,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
);

    localparam int unsigned BIT_IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0]    LAST_WAIT = WAIT_W'(RD_LAT - 1);

    state_e                 state_q, state_d;
    logic [N-1:0]           addr_q, addr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [CNT_W-1:0]       sent_q, sent_d;
    logic [N-1:0]           shift_q, shift_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic                   out_q, out_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_en_q, rd_en_d;
    logic [N-1:0]           mem_addr_q, mem_addr_d;
    logic                   tick;
`ifdef FIR_STREAM_PARITY_EN
    logic                   par_q, par_d;
`endif

    // Timer is realigned while waiting for read data so the start bit gets a full period.
    fir_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == S_WAIT),
        .tick_c_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        sent_d     = sent_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        wait_d     = wait_q;
`ifdef FIR_STREAM_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = count;
                    sent_d  = '0;
                    state_d = (count == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    shift_d = mem_rdata;
`ifdef FIR_STREAM_PARITY_EN
                    par_d   = ^mem_rdata;
`endif
                    state_d = S_START_B;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_START_B: begin
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA_B;
                end
            end
            S_DATA_B: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef FIR_STREAM_PARITY_EN
                        state_d = S_PAR_B;
`else
                        state_d = S_STOP_B;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    end
                end
            end
`ifdef FIR_STREAM_PARITY_EN
            S_PAR_B: begin
                if (tick) begin
                    state_d = S_STOP_B;
                end
            end
`endif
            S_STOP_B: begin
                if (tick) begin
                    sent_d  = sent_q + CNT_W'(1);
                    addr_d  = addr_q + N'(1);
                    state_d = (sent_d == count_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        out_d      = IDLE_LEVEL;
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        rd_en_d    = (state_d == S_FETCH);
        mem_addr_d = (state_d == S_FETCH) ? addr_d : mem_addr_q;
        case (state_d)
            S_START_B: out_d = START_LEVEL;
            S_DATA_B:  out_d = shift_d[0];
`ifdef FIR_STREAM_PARITY_EN
            S_PAR_B:   out_d = par_d;
`endif
            default:   out_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            sent_q     <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            wait_q     <= '0;
            out_q      <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            mem_addr_q <= '0;
`ifdef FIR_STREAM_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            wait_q     <= wait_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            mem_addr_q <= mem_addr_d;
`ifdef FIR_STREAM_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign sent      = sent_q;

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed + randomized bench for fir_result_streamer against a cycle-level waveform model.
// Honours FIR_STREAM_PARITY_EN the same way as the design.
module tb_fir_result_streamer;
    import fir_stream_pkg::*;

    localparam int unsigned N     = 24;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned CPB   = 4;
    localparam int unsigned RDL   = 1;
`ifdef FIR_STREAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     base_addr;
    logic [CNT_W-1:0] count;
    logic [N-1:0]     mem_addr;
    logic             mem_rd_en;
    logic [N-1:0]     mem_rdata;
    logic             out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sent;

    logic [N-1:0] mem [0:255];
    int n_checks = 0;
    int n_pass   = 0;

    fir_result_streamer #(
        .N(N), .CNT_W(CNT_W), .CLKS_PER_BIT(CPB), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .out(out), .busy(busy), .done(done), .sent(sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle-latency memory read port.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag, input int exp_sent);
        check({tag, "_out"},  32'(out), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rden"}, 32'(mem_rd_en), 32'd0);
        check({tag, "_sent"}, 32'(sent), 32'(exp_sent));
    endtask

    // Runs one block; abort_at > 0 stops after that many observed cycles.
    task automatic run_block(input string tag, input logic [N-1:0] base, input int cnt, input int abort_at);
        bit          eo[$], er[$], ed[$], eb[$];
        int          es[$];
        logic [N-1:0] ea[$];
        logic [N-1:0] a, word;
        bit          fb[$];
        int          len, done_at, exp_done_at;

        for (int w = 0; w < cnt; w++) begin
            a    = base + N'(w);
            word = mem[a[7:0]];
            for (int g = 0; g < 1 + int'(RDL); g++) begin
                eo.push_back(1'b1); er.push_back(g == 0); ed.push_back(1'b0);
                eb.push_back(1'b1); es.push_back(w); ea.push_back(a);
            end
            fb.delete();
            fb.push_back(1'b0);
            for (int b = 0; b < int'(N); b++) fb.push_back(word[b]);
            if (PAR) fb.push_back(^word);
            fb.push_back(1'b1);
            foreach (fb[k]) begin
                for (int c = 0; c < int'(CPB); c++) begin
                    eo.push_back(fb[k]); er.push_back(1'b0); ed.push_back(1'b0);
                    eb.push_back(1'b1); es.push_back(w); ea.push_back('0);
                end
            end
        end
        eo.push_back(1'b1); er.push_back(1'b0); ed.push_back(1'b1);
        eb.push_back(1'b0); es.push_back(cnt); ea.push_back('0);

        @(negedge clk);
        start = 1'b1; base_addr = base; count = CNT_W'(cnt);
        @(posedge clk);
        len = (abort_at > 0 && abort_at < eo.size()) ? abort_at : eo.size();
        done_at = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            check({tag, "_out"},  32'(out),       32'(eo[i]));
            check({tag, "_rden"}, 32'(mem_rd_en), 32'(er[i]));
            check({tag, "_done"}, 32'(done),      32'(ed[i]));
            check({tag, "_busy"}, 32'(busy),      32'(eb[i]));
            check({tag, "_sent"}, 32'(sent),      32'(es[i]));
            if (er[i]) check({tag, "_addr"}, 32'(mem_addr), 32'(ea[i]));
            if (done && done_at < 0) done_at = i + 1;
            start     = (i == len - 1) ? 1'b1 : 1'($urandom % 2);
            base_addr = N'($urandom);
            count     = CNT_W'($urandom);
        end
        if (abort_at > 0) begin
            start = 1'b0;
            return;
        end
        exp_done_at = cnt * (1 + int'(RDL) + int'(frame_bits(N, PAR) * CPB)) + 1;
        check({tag, "_done_lat"}, 32'(done_at), 32'(exp_done_at));
        @(negedge clk);
        check_quiet({tag, "_post1"}, cnt);
        start = 1'b0;
        @(negedge clk);
        check_quiet({tag, "_post2"}, cnt);
    endtask

    initial begin
        logic [N-1:0] rb;
        rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        for (int i = 0; i < 256; i++) mem[i] = N'($urandom);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("rst_hold", 0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("rst_rel", 0);

        mem[8'h10] = 24'hA5A5A5;
        run_block("single", 24'h000010, 1, 0);

        mem[0] = 24'h000001; mem[1] = 24'h800000; mem[2] = 24'hFFFFFF;
        run_block("three", 24'h000000, 3, 0);

        run_block("zero", 24'h000040, 0, 0);

        // Bit 7 of the first word is 0 so an idle-high line after reset is distinguishable.
        mem[8'h20] = 24'h00007F; mem[8'h21] = 24'h123456;
        run_block("abort", 24'h000020, 2, 36);
        rst = 1'b0;
        @(negedge clk);
        check_quiet("abort_rst", 0);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort_rel", 0);
        run_block("after_abort", 24'h000021, 1, 0);

        mem[8'h30] = 24'h000007; mem[8'h31] = 24'h000003;
        run_block("parity", 24'h000030, 2, 0);

        mem[8'hFF] = N'($urandom); mem[8'h00] = N'($urandom);
        run_block("wrap", 24'hFFFFFF, 2, 0);

        for (int r = 0; r < 4; r++) begin
            rb = N'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) mem[8'(rb + N'(k))] = N'($urandom);
            run_block("rand", rb, int'($urandom_range(1, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
